// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-lane data memory.
// Covers access sizes, the clear/run FSM state, byte enables, store replication and load extension.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = lane[0];
      SIZE_WORD: is_misaligned = (lane != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: be_gen = 4'b0001 << lane;
      SIZE_HALF: be_gen = 4'b0011 << lane;
      SIZE_WORD: be_gen = 4'b1111;
      default:   be_gen = 4'b0000;
    endcase
  endfunction

  // Sub-word stores replicate the data so every enabled lane already sees its bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: store_data = {4{wdata[7:0]}};
      SIZE_HALF: store_data = {2{wdata[15:0]}};
      default:   store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_HALF: load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default:   load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_bank.sv
// DEPTH x 32-bit storage with per-byte write enables and a registered read-first port.
// Kept free of reset so it maps onto block RAM.
module data_memory_bank #(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read samples the pre-write contents of the same word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[idx];
    end
    for (int l = 0; l < 4; l++) begin
      if (we && be[l]) begin
        mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed MEM-stage data memory: clear sweep after reset, sized loads/stores,
// misalignment flagging and a one-cycle registered load path.
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        misaligned
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             req_ready_q, req_ready_d;
  logic             read_valid_q, read_valid_d;
  logic             misaligned_q, misaligned_d;
  logic             zero_q, zero_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;

  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane;
  logic             accept;
  logic             bad;
  logic             bank_we, bank_re;
  logic [3:0]       bank_be;
  logic [IDX_W-1:0] bank_idx;
  logic [31:0]      bank_wdata, bank_rdata;
  logic             unused_addr;

  assign unused_addr = ^address[31:IDX_W+2];

  always_comb begin
    req_idx    = address[IDX_W+1:2];
    req_lane   = address[1:0];
    accept     = req_valid & req_ready_q & (mem_read | mem_write);
    bad        = is_misaligned(size, req_lane);
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    bank_we    = 1'b0;
    bank_re    = 1'b0;
    bank_be    = 4'b1111;
    bank_idx   = req_idx;
    bank_wdata = 32'd0;

    if (state_q == CLEAR) begin
      bank_we   = 1'b1;
      bank_idx  = clr_idx_q;
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end else begin
      bank_we    = accept & mem_write & ~bad;
      bank_re    = accept & mem_read & ~bad;
      bank_be    = be_gen(size, req_lane);
      bank_wdata = store_data(size, write_data);
    end

    // Nothing touches the array while reset is being sampled.
    if (!reset) begin
      bank_we = 1'b0;
      bank_re = 1'b0;
    end

    req_ready_d  = (state_d == RUN);
    read_valid_d = accept & mem_read;
    misaligned_d = accept & bad;

    zero_d = zero_q;
    if (accept & bad) begin
      zero_d = 1'b1;
    end else if (bank_re) begin
      zero_d = 1'b0;
    end

    lane_d = bank_re ? req_lane      : lane_q;
    size_d = bank_re ? size          : size_q;
    uns_d  = bank_re ? load_unsigned : uns_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_idx_q    <= '0;
      req_ready_q  <= 1'b0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      req_ready_q  <= req_ready_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
      zero_q       <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    lane_q <= lane_d;
    size_q <= size_d;
    uns_q  <= uns_d;
  end

  data_memory_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .re    (bank_re),
    .be    (bank_be),
    .idx   (bank_idx),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Lane select and extension sit after the bank's output register; only loads update their controls.
  assign read_data  = zero_q ? 32'd0 : load_extend(bank_rdata, lane_q, size_q, uns_q);
  assign read_valid = read_valid_q;
  assign misaligned = misaligned_q;
  assign req_ready  = req_ready_q;

endmodule
